// File: rtl/prog_mem_loader_pkg.sv
// Shared constants and FSM state encoding for the node program-memory loader
// and the core fetch logic that reads the same RAM.
package prog_mem_loader_pkg;

   localparam int WIDTH = 18;   // instruction word width
   localparam int DEPTH = 26;   // program words per node
   localparam int AW    = 8;    // fetch address width
   localparam int CW    = 5;    // write address / word counter width

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_B0    = 3'd2,
      S_B1    = 3'd3,
      S_B2    = 3'd4,
      S_WRITE = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

endpackage

// File: rtl/prog_mem_loader_prog_ram.sv
// 26 x 18 program RAM: synchronous write, combinational read that returns
// zero for any fetch address outside the program area.
module prog_ram
   import prog_mem_loader_pkg::*;
(
   input  logic             clk,
   input  logic             we,
   input  logic [0:CW-1]    waddr,
   input  logic [0:WIDTH-1] wdata,
   input  logic [0:AW-1]    raddr,
   output logic [0:WIDTH-1] rdata
);

   logic [0:WIDTH-1] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Range check first so the low address bits only ever index a real entry.
   assign rdata = (raddr < AW'(DEPTH)) ? mem[raddr[AW-CW:AW-1]] : '0;

endmodule

// File: rtl/prog_mem_loader.sv
// Program loader for a TIS-100 node: a length header followed by three bytes
// per 18-bit word, written sequentially into the program RAM.
module prog_mem_loader
   import prog_mem_loader_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [0:7]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [0:AW-1]    rd_addr,
   output logic [0:WIDTH-1] rd_data,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [0:CW-1]    words_loaded,
   output logic [2:0]       state_dbg
);

   state_t           state_q, state_d;
   logic [0:CW-1]    len_q, len_d;
   logic [0:CW-1]    wcnt_q, wcnt_d;
   logic [0:WIDTH-1] word_q, word_d;
   logic             error_q, error_d;
   logic             we;
   logic             accept;
   logic             hdr_bad;

   // Handshake: a byte transfers on a posedge where in_valid && in_ready;
   // in_ready depends only on state, never on in_valid.
   assign in_ready     = state_q inside {S_LEN, S_B0, S_B1, S_B2};
   assign accept       = in_valid && in_ready;
   assign hdr_bad      = (in_data == 8'd0) || (in_data > 8'(DEPTH));
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign error        = error_q;
   assign words_loaded = wcnt_q;
   assign state_dbg    = state_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         wcnt_q  <= '0;
         word_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         word_q  <= word_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      word_d  = word_q;
      error_d = error_q;
      we      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LEN;
               error_d = 1'b0;
               wcnt_d  = '0;
            end
         end
         S_LEN: begin
            if (accept) begin
               if (hdr_bad) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end else begin
                  len_d   = in_data[3:7];
                  state_d = S_B0;
               end
            end
         end
         S_B0: begin
            if (accept) begin
               word_d[0:1] = in_data[6:7];
               state_d     = S_B1;
            end
         end
         S_B1: begin
            if (accept) begin
               word_d[2:9] = in_data;
               state_d     = S_B2;
            end
         end
         S_B2: begin
            if (accept) begin
               word_d[10:17] = in_data;
               state_d       = S_WRITE;
            end
         end
         S_WRITE: begin
            we     = 1'b1;
            wcnt_d = wcnt_q + CW'(1);
            // The counter doubles as the write address, so it stops at N <= DEPTH.
            state_d = (wcnt_q + CW'(1) == len_q) ? S_DONE : S_B0;
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   prog_ram u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (wcnt_q),
      .wdata (word_q),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed plus randomized bench for prog_mem_loader, checked against a
// word-level model of the program RAM and load outcomes.
module tb_prog_mem_loader;
   import prog_mem_loader_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  rd_addr;
   logic [17:0] rd_data;
   logic        busy;
   logic        done;
   logic        error;
   logic [4:0]  words_loaded;
   logic [2:0]  state_dbg;

   logic [17:0] ld_words [26];
   logic [17:0] ref_mem  [26];
   int          errors;
   int          checks;
   int          done_seen;
   int          ready_bad;

   prog_mem_loader dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded),
      .state_dbg    (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // monitors: done pulse count and in_ready outside the byte-accepting states
   always @(negedge clk) begin
      if (!reset && done) done_seen++;
      if (!reset && in_ready && !(state_dbg inside {3'd1, 3'd2, 3'd3, 3'd4})) ready_bad++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver: starts and ends on a negedge
   task automatic send_byte(input logic [7:0] b, input int gap_mode);
      int t;
      if (gap_mode == 1) repeat (1) @(negedge clk);
      if (gap_mode == 2) repeat ($urandom_range(0, 2)) @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) check("ready_timeout", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (busy && t < 50) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic check_ram(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         rd_addr = 8'(i);
         @(negedge clk);
         check($sformatf("%s_ram%0d", tag, i), rd_data, ref_mem[i]);
      end
   endtask

   function automatic logic [7:0] byte0(input logic [17:0] w, input bit junk);
      logic [5:0] hi;
      hi = junk ? 6'($urandom) : 6'd0;
      return {hi, w[17:16]};
   endfunction

   task automatic run_load(input int n, input int gap_mode, input bit junk, input string tag);
      int d0;
      d0 = done_seen;
      pulse_start();
      send_byte(8'(n), gap_mode);
      for (int i = 0; i < n; i++) begin
         send_byte(byte0(ld_words[i], junk), gap_mode);
         send_byte(ld_words[i][15:8], gap_mode);
         send_byte(ld_words[i][7:0], gap_mode);
         ref_mem[i] = ld_words[i];
      end
      wait_idle(tag);
      check({tag, "_done"}, done_seen - d0, 1);
      check({tag, "_words"}, words_loaded, n);
      check({tag, "_err"}, error, 0);
      check_ram(tag, n);
   endtask

   initial begin
      int d0;
      errors    = 0;
      checks    = 0;
      done_seen = 0;
      ready_bad = 0;
      reset     = 1'b1;
      start     = 1'b0;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      rd_addr   = 8'h00;
      repeat (2) @(negedge clk);

      // reset state
      check("rst_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_words", words_loaded, 0);
      check("rst_state", state_dbg, 0);
      reset = 1'b0;
      @(negedge clk);

      // known two-word program, ungapped
      ld_words[0] = 18'h1ABCD;
      ld_words[1] = 18'h300FF;
      run_load(2, 0, 1'b0, "two");
      rd_addr = 8'd0;
      #1 check("two_w0_const", rd_data, 18'b01_10101011_11001101);
      rd_addr = 8'd1;
      #1 check("two_w1_const", rd_data, 18'b11_00000000_11111111);
      @(negedge clk);

      // full random program with random valid gaps and junk in ignored bits
      for (int i = 0; i < 26; i++) ld_words[i] = 18'($urandom);
      run_load(26, 2, 1'b1, "full");

      // bad header 0x00
      pulse_start();
      send_byte(8'h00, 0);
      check("hdr0_err", error, 1);
      check("hdr0_words", words_loaded, 0);
      @(negedge clk);
      check("hdr0_busy", busy, 0);
      repeat (3) @(negedge clk);
      check("hdr0_sticky", error, 1);
      check("hdr0_done", done_seen, 2);
      // next start clears error; header 27 is rejected
      pulse_start();
      check("hdr27_clr", error, 0);
      send_byte(8'h1B, 0);
      check("hdr27_err", error, 1);
      @(negedge clk);
      check("hdr27_busy", busy, 0);
      check_ram("noerrwr", 26);

      // one-word load with in_valid toggling every cycle
      ld_words[0] = 18'($urandom);
      run_load(1, 1, 1'b1, "gap");
      check("ready_states", ready_bad, 0);

      // start pulsed while in B1
      ld_words[0] = 18'($urandom);
      d0 = done_seen;
      pulse_start();
      send_byte(8'd1, 0);
      send_byte(byte0(ld_words[0], 1'b1), 0);
      check("b1_state", state_dbg, 3'(S_B1));
      pulse_start();
      check("b1_hold", state_dbg, 3'(S_B1));
      check("b1_busy", busy, 1);
      send_byte(ld_words[0][15:8], 0);
      send_byte(ld_words[0][7:0], 0);
      ref_mem[0] = ld_words[0];
      wait_idle("b1");
      check("b1_done", done_seen - d0, 1);
      check("b1_words", words_loaded, 1);
      check_ram("b1", 1);

      // reset after the first of three words is written
      for (int i = 0; i < 3; i++) ld_words[i] = ref_mem[i] ^ 18'h2AAAA;
      pulse_start();
      send_byte(8'd3, 0);
      send_byte(byte0(ld_words[0], 1'b1), 0);
      send_byte(ld_words[0][15:8], 0);
      send_byte(ld_words[0][7:0], 0);
      @(negedge clk);
      check("mid_words1", words_loaded, 1);
      ref_mem[0] = ld_words[0];
      #2 reset = 1'b1;
      #1;
      check("mid_ready", in_ready, 0);
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_error", error, 0);
      check("mid_words", words_loaded, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_ram("mid", 3);

      // fresh full load after reset
      for (int i = 0; i < 26; i++) ld_words[i] = 18'($urandom);
      run_load(26, 2, 1'b1, "fresh");

      // same-cycle read/write of address 0
      ld_words[0] = ref_mem[0] ^ 18'h15555;
      rd_addr = 8'd0;
      pulse_start();
      send_byte(8'd1, 0);
      send_byte(byte0(ld_words[0], 1'b1), 0);
      send_byte(ld_words[0][15:8], 0);
      send_byte(ld_words[0][7:0], 0);
      check("rw_old", rd_data, ref_mem[0]);
      @(negedge clk);
      check("rw_new", rd_data, ld_words[0]);
      ref_mem[0] = ld_words[0];
      wait_idle("rw");

      // out-of-range fetch addresses
      rd_addr = 8'd26;
      #1 check("oor_26", rd_data, 0);
      rd_addr = 8'd255;
      #1 check("oor_255", rd_data, 0);
      rd_addr = 8'd25;
      #1 check("last_25", rd_data, ref_mem[25]);

      check("ready_states_end", ready_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
